brsf_mc_fifo: RTL and testbench
===============================

// Module: brsf_mc_fifo
// PURPOSE
//  Multi-channel synchronous FIFO. pChan independent FIFOs share one inferred block RAM.
//  Each channel has its own pointers, word count and flags.
//  Any-channel write plus any-channel read per clock. Successor to the single-channel
//  block RAM FIFO, for multi-port UART/SPI buffering in one BRAM.
// PARAMETERS
//  pChan   4  number of channels (power of 2, >=2)
//  pAddr   8  per-channel address bits; depth D = 2**pAddr
//  pWidth  8  data bits
//  pSelW   2  channel select bits = log2(pChan)
// PORTS
//  Clk    in   1            system clock, single clock domain
//  Rst    in   1            synchronous, active-high reset
//  Clr    in   pChan        per-channel synchronous clear
//  WE     in   1            write enable
//  WSel   in   pSelW        write channel
//  DI     in   pWidth       write data
//  RE     in   1            read enable
//  RSel   in   pSelW        read channel
//  DO     out  pWidth       read data, valid when ACK=1
//  ACK    out  1            read acknowledge
//  ACKSel out  pSelW        channel of the data on DO
//  FF/AF/HF/AE/EF out pChan per-channel full / D-1 / >=D/2 / ==1 / ==0 flags
//  Cnt    out  pChan*(pAddr+1)  packed per-channel counts; ch k at [k*(pAddr+1)+:pAddr+1]
// BEHAVIOUR
//  - Wr = WE & ~FF[WSel] & ~Clr[WSel]; Rd = RE & ~EF[RSel] & ~Clr[RSel]. Blocked ops are dropped.
//  - RAM address is {sel, ptr}. Writes are stored at the next edge.
//  - Read latency is 1: after a Rd at edge n, at edge n+1 DO = RAM[{RSel,RPtr}], ACK=1, ACKSel=RSel.
//  - Cnt[k]: +1 on Wr only to k, -1 on Rd only from k, unchanged on Wr and Rd to the same k.
//  - Cnt width is pAddr+1, so D is representable. Pointers wrap modulo D.
//  - All flags are registered and derived from the next-state count, so they are valid the
//    same edge the count changes.
//  - Flag definitions: EF = 0, AE = 1, AF = D-1, FF = D, HF >= D/2.
//  - Write to an empty channel plus a read of that same channel in one cycle: the read is
//    blocked (EF=1) and the write proceeds. No fall-through.
//  - Same-channel read and write while full: the read proceeds and the write is blocked
//    (FF=1). Count goes to D-1 and AF=1.
//  - Different channels: both operations are independent, including one channel full and
//    another empty.
//  - Clr[k] has priority over Wr/Rd on k for that edge. Effects: pointers and Cnt[k] go to 0,
//    EF[k]=1, all other flags 0. Other channels are unaffected.
//  - Clr[RSel] together with a pending RE gives ACK=0 next cycle.
//  - Reset values: all pointers/Cnt = 0, EF = all ones, FF/AF/HF/AE = 0, ACK = 0,
//    ACKSel = 0, DO = 0 (output register sync reset).
//  - RAM contents are not cleared.
//  - Rst mid-operation: an in-flight read is discarded and ACK=0 on the next cycle.
//    Rst overrides Clr.
// CONFIGURATION
//  - Macro BRSF_MC_ERR_EN, when defined, adds outputs OVF[pChan] and UNF[pChan]:
//    - OVF[k] is set sticky on WE with WSel=k while FF[k]=1.
//    - UNF[k] is set sticky on RE with RSel=k while EF[k]=1.
//    - Both are cleared by Rst or Clr[k] and reset to 0.
//  - Without the macro these ports and their registers do not exist. Dropped accesses are
//    silent.
// STRUCTURE
//  - Package brsf_pkg holds:
//    - clog2 function
//    - flag bit-index constants (FLG_EF..FLG_FF)
//    - count-width localparam helper
//  - Sub-module brsf_chan_ctrl covers one channel's WPtr, RPtr, Cnt and the five flags
//    (plus the optional OVF/UNF). It is instantiated pChan times via generate.
//  - The top level holds the shared RAM, select muxes, ACK/ACKSel/DO registers and
//    Cnt packing.
// TESTING
//  - Reset: after Rst, EF=4'hF, Cnt all 0, ACK=0, DO=0. RE on ch2 gives ACK=0
//    (UNF[2]=1 if ERR_EN).
//  - Fill/drain ch1, pAddr=4: 16 writes give FF[1]=1 at count 16 and AF[1] at 15, HF[1] at 8.
//    A 17th write is dropped (OVF[1]). 16 reads return data in order and EF[1]=1.
//  - Interleave: write ch0=A5 and ch3=3C, then RE ch3 then ch0. Expect DO=3C/ACKSel=3,
//    then DO=A5/ACKSel=0.
//  - Same-cycle: ch2 empty, WE+RE on ch2 gives Cnt[2]=1, ACK=0. Next cycle WE+RE on ch2:
//    Cnt stays 1, ACK=1 with the first word.
//  - Clr[1] while ch1 has 5 words and ch0 has 3: Cnt[1]=0, EF[1]=1, Cnt[0]=3 with data intact.
//  - Pointer wrap: 3xD writes/reads on ch3 with a random pattern; scoreboard matches and
//    Cnt never exceeds D.

Source files
------------

// File: rtl/brsf_mc_fifo_pkg.sv
// Shared constants and helpers for the brsf multi-channel FIFO.
// Flag vectors are indexed with FLG_* so every module agrees on bit order.
package brsf_pkg;

    localparam int FLG_EF = 0;
    localparam int FLG_AE = 1;
    localparam int FLG_HF = 2;
    localparam int FLG_AF = 3;
    localparam int FLG_FF = 4;
    localparam int FLG_N  = 5;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // One extra bit so a completely full channel (count == depth) is representable.
    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/brsf_mc_fifo_chan_ctrl.sv
// Per-channel bookkeeping: write/read pointers, word count and registered flags.
// Optional sticky OVF/UNF outputs exist only when BRSF_MC_ERR_EN is defined.
module brsf_chan_ctrl
    import brsf_pkg::*;
#(
    parameter int pAddr = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Clr,
    input  logic             i_WE,
    input  logic             i_RE,
    output logic             o_Wr,
    output logic             o_Rd,
    output logic [pAddr-1:0] o_WPtr,
    output logic [pAddr-1:0] o_RPtr,
    output logic [pAddr:0]   o_Cnt,
    output logic [FLG_N-1:0] o_Flg
`ifdef BRSF_MC_ERR_EN
    ,
    output logic             o_OVF,
    output logic             o_UNF
`endif
);

    localparam int            CW   = cnt_w(pAddr);
    localparam logic [CW-1:0] D    = CW'(2 ** pAddr);
    localparam logic [CW-1:0] HALF = CW'(2 ** (pAddr - 1));

    logic [pAddr-1:0] r_wptr;
    logic [pAddr-1:0] r_rptr;
    logic [CW-1:0]    r_cnt;
    logic [FLG_N-1:0] r_flg;
    logic [CW-1:0]    w_cnt_nxt;
    logic [FLG_N-1:0] w_flg_nxt;
    logic             w_wr;
    logic             w_rd;

    // Clear wins over both accesses; full/empty gating uses the registered flags.
    assign w_wr = i_WE & ~r_flg[FLG_FF] & ~i_Clr;
    assign w_rd = i_RE & ~r_flg[FLG_EF] & ~i_Clr;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_Clr)
            w_cnt_nxt = '0;
        else if (w_wr && !w_rd)
            w_cnt_nxt = r_cnt + CW'(1);
        else if (w_rd && !w_wr)
            w_cnt_nxt = r_cnt - CW'(1);
    end

    always_comb begin
        w_flg_nxt         = '0;
        w_flg_nxt[FLG_EF] = (w_cnt_nxt == '0);
        w_flg_nxt[FLG_AE] = (w_cnt_nxt == CW'(1));
        w_flg_nxt[FLG_HF] = (w_cnt_nxt >= HALF);
        w_flg_nxt[FLG_AF] = (w_cnt_nxt == D - CW'(1));
        w_flg_nxt[FLG_FF] = (w_cnt_nxt == D);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_flg  <= FLG_N'(1 << FLG_EF);
        end else begin
            r_cnt <= w_cnt_nxt;
            r_flg <= w_flg_nxt;
            if (i_Clr) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_wr) r_wptr <= r_wptr + 1'b1;
                if (w_rd) r_rptr <= r_rptr + 1'b1;
            end
        end
    end

`ifdef BRSF_MC_ERR_EN
    logic r_ovf;
    logic r_unf;

    always_ff @(posedge i_Clk) begin
        if (i_Rst || i_Clr) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (i_WE && r_flg[FLG_FF]) r_ovf <= 1'b1;
            if (i_RE && r_flg[FLG_EF]) r_unf <= 1'b1;
        end
    end

    assign o_OVF = r_ovf;
    assign o_UNF = r_unf;
`endif

    assign o_Wr   = w_wr;
    assign o_Rd   = w_rd;
    assign o_WPtr = r_wptr;
    assign o_RPtr = r_rptr;
    assign o_Cnt  = r_cnt;
    assign o_Flg  = r_flg;

endmodule

// File: rtl/brsf_mc_fifo.sv
// Multi-channel synchronous FIFO: pChan queues share one block RAM addressed {sel, ptr}.
// Define BRSF_MC_ERR_EN to add sticky per-channel OVF/UNF outputs.
module brsf_mc_fifo
    import brsf_pkg::*;
#(
    parameter int pChan  = 4,
    parameter int pAddr  = 8,
    parameter int pWidth = 8,
    parameter int pSelW  = 2
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst,
    input  logic [pChan-1:0]            i_Clr,
    input  logic                        i_WE,
    input  logic [pSelW-1:0]            i_WSel,
    input  logic [pWidth-1:0]           i_DI,
    input  logic                        i_RE,
    input  logic [pSelW-1:0]            i_RSel,
    output logic [pWidth-1:0]           o_DO,
    output logic                        o_ACK,
    output logic [pSelW-1:0]            o_ACKSel,
    output logic [pChan-1:0]            o_FF,
    output logic [pChan-1:0]            o_AF,
    output logic [pChan-1:0]            o_HF,
    output logic [pChan-1:0]            o_AE,
    output logic [pChan-1:0]            o_EF,
    output logic [pChan*(pAddr+1)-1:0]  o_Cnt
`ifdef BRSF_MC_ERR_EN
    ,
    output logic [pChan-1:0]            o_OVF,
    output logic [pChan-1:0]            o_UNF
`endif
);

    localparam int CW = cnt_w(pAddr);
    localparam int AW = clog2(pChan) + pAddr;

    logic [pWidth-1:0] r_mem [0:(2**AW)-1];
    logic [pAddr-1:0]  w_wptr [pChan];
    logic [pAddr-1:0]  w_rptr [pChan];
    logic [pChan-1:0]  w_wr;
    logic [pChan-1:0]  w_rd;
    logic [AW-1:0]     w_waddr;
    logic [AW-1:0]     w_raddr;
    logic              w_wr_sel;
    logic              w_rd_sel;
    logic [pWidth-1:0] r_do;
    logic              r_ack;
    logic [pSelW-1:0]  r_acksel;

    for (genvar k = 0; k < pChan; k++) begin : g_chan
        logic [FLG_N-1:0] w_flg;
        logic [CW-1:0]    w_cnt;

        brsf_chan_ctrl #(.pAddr(pAddr)) u_ctrl (
            .i_Clk  (i_Clk),
            .i_Rst  (i_Rst),
            .i_Clr  (i_Clr[k]),
            .i_WE   (i_WE && (i_WSel == pSelW'(k))),
            .i_RE   (i_RE && (i_RSel == pSelW'(k))),
            .o_Wr   (w_wr[k]),
            .o_Rd   (w_rd[k]),
            .o_WPtr (w_wptr[k]),
            .o_RPtr (w_rptr[k]),
            .o_Cnt  (w_cnt),
            .o_Flg  (w_flg)
`ifdef BRSF_MC_ERR_EN
            ,
            .o_OVF  (o_OVF[k]),
            .o_UNF  (o_UNF[k])
`endif
        );

        assign o_EF[k]           = w_flg[FLG_EF];
        assign o_AE[k]           = w_flg[FLG_AE];
        assign o_HF[k]           = w_flg[FLG_HF];
        assign o_AF[k]           = w_flg[FLG_AF];
        assign o_FF[k]           = w_flg[FLG_FF];
        assign o_Cnt[k*CW +: CW] = w_cnt;
    end

    assign w_waddr  = {i_WSel, w_wptr[i_WSel]};
    assign w_raddr  = {i_RSel, w_rptr[i_RSel]};
    assign w_wr_sel = w_wr[i_WSel] & ~i_Rst;
    assign w_rd_sel = w_rd[i_RSel];

    // RAM has no reset so it maps onto block RAM; stale words are never exposed.
    always_ff @(posedge i_Clk) begin
        if (w_wr_sel) r_mem[w_waddr] <= i_DI;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_ack    <= 1'b0;
            r_acksel <= '0;
            r_do     <= '0;
        end else begin
            r_ack <= w_rd_sel;
            if (w_rd_sel) begin
                r_acksel <= i_RSel;
                r_do     <= r_mem[w_raddr];
            end
        end
    end

    assign o_DO     = r_do;
    assign o_ACK    = r_ack;
    assign o_ACKSel = r_acksel;

endmodule

// File: tb/tb_brsf_mc_fifo.sv
// Self-checking bench for brsf_mc_fifo (pChan=4, pAddr=4): queue model plus directed literals.
module tb_brsf_mc_fifo;

    localparam int pChan  = 4;
    localparam int pAddr  = 4;
    localparam int pWidth = 8;
    localparam int pSelW  = 2;
    localparam int D      = 16;
    localparam int CW     = 5;

    logic                  clk;
    logic                  rst;
    logic [pChan-1:0]      clr;
    logic                  we;
    logic [pSelW-1:0]      wsel;
    logic [pWidth-1:0]     di;
    logic                  re;
    logic [pSelW-1:0]      rsel;
    logic [pWidth-1:0]     dout;
    logic                  ack;
    logic [pSelW-1:0]      acksel;
    logic [pChan-1:0]      ff, af, hf, ae, ef;
    logic [pChan*CW-1:0]   cnt;
`ifdef BRSF_MC_ERR_EN
    logic [pChan-1:0]      ovf, unf;
    logic [pChan-1:0]      m_ovf, m_unf;
`endif

    brsf_mc_fifo #(.pChan(pChan), .pAddr(pAddr), .pWidth(pWidth), .pSelW(pSelW)) dut (
        .i_Clk    (clk),
        .i_Rst    (rst),
        .i_Clr    (clr),
        .i_WE     (we),
        .i_WSel   (wsel),
        .i_DI     (di),
        .i_RE     (re),
        .i_RSel   (rsel),
        .o_DO     (dout),
        .o_ACK    (ack),
        .o_ACKSel (acksel),
        .o_FF     (ff),
        .o_AF     (af),
        .o_HF     (hf),
        .o_AE     (ae),
        .o_EF     (ef),
        .o_Cnt    (cnt)
`ifdef BRSF_MC_ERR_EN
        ,
        .o_OVF    (ovf),
        .o_UNF    (unf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pushes3 = 0;

    logic [7:0] mq [4][$];
    logic       exp_ack = 1'b0;
    logic [7:0] exp_do  = '0;
    int         exp_as  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int cnt_of(input int k);
        return int'(cnt[k*CW +: CW]);
    endfunction

    function automatic logic [7:0] dat(input int i);
        return 8'((i * 37 + 5) & 255);
    endfunction

    // Reference behaviour: one queue per channel, evaluated from the pre-edge state.
    task automatic model_step();
        bit wr;
        bit rd;
        int ws;
        int rs;
        ws = int'(wsel);
        rs = int'(rsel);
        if (rst) begin
            for (int k = 0; k < pChan; k++) mq[k].delete();
            exp_ack = 1'b0;
`ifdef BRSF_MC_ERR_EN
            m_ovf = '0;
            m_unf = '0;
`endif
        end else begin
            wr = we && (mq[ws].size() < D) && !clr[ws];
            rd = re && (mq[rs].size() > 0) && !clr[rs];
`ifdef BRSF_MC_ERR_EN
            for (int k = 0; k < pChan; k++) begin
                if (clr[k]) begin
                    m_ovf[k] = 1'b0;
                    m_unf[k] = 1'b0;
                end else begin
                    if (we && ws == k && mq[k].size() == D) m_ovf[k] = 1'b1;
                    if (re && rs == k && mq[k].size() == 0) m_unf[k] = 1'b1;
                end
            end
`endif
            exp_ack = rd;
            if (rd) begin
                exp_do = mq[rs].pop_front();
                exp_as = rs;
            end
            for (int k = 0; k < pChan; k++) if (clr[k]) mq[k].delete();
            if (wr) begin
                mq[ws].push_back(di);
                if (ws == 3) pushes3++;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        for (int k = 0; k < pChan; k++) begin
            int n;
            n = mq[k].size();
            chk($sformatf("cnt%0d", k), cnt_of(k), n);
            chk($sformatf("flags%0d", k), int'({ff[k], af[k], hf[k], ae[k], ef[k]}),
                int'({n == D, n == D - 1, n >= D / 2, n == 1, n == 0}));
        end
        chk("ack", int'(ack), int'(exp_ack));
        if (exp_ack) begin
            chk("do", int'(dout), int'(exp_do));
            chk("acksel", int'(acksel), exp_as);
        end
`ifdef BRSF_MC_ERR_EN
        chk("ovf", int'(ovf), int'(m_ovf));
        chk("unf", int'(unf), int'(m_unf));
`endif
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input int ws, input logic [7:0] d,
                         input logic r, input int rs, input logic [3:0] c);
        we   = w;
        wsel = 2'(ws);
        di   = d;
        re   = r;
        rsel = 2'(rs);
        clr  = c;
        tick();
        we  = 1'b0;
        re  = 1'b0;
        clr = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; clr = '0;
        wsel = '0; rsel = '0; di = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ef", int'(ef), 15);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_do", int'(dout), 0);

        drive(1'b0, 0, 8'h00, 1'b1, 2, 4'h0);
        chk("empty_re_ack", int'(ack), 0);
`ifdef BRSF_MC_ERR_EN
        chk("unf2", int'(unf[2]), 1);
`endif

        // Fill and drain channel 1.
        for (int i = 0; i < D; i++) begin
            drive(1'b1, 1, dat(i), 1'b0, 0, 4'h0);
            if (i == 6) chk("hf1_at7", int'(hf[1]), 0);
            if (i == 7) chk("hf1_at8", int'(hf[1]), 1);
            if (i == 14) begin
                chk("af1_at15", int'(af[1]), 1);
                chk("ff1_at15", int'(ff[1]), 0);
            end
        end
        chk("ff1_full", int'(ff[1]), 1);
        chk("cnt1_full", cnt_of(1), 16);
        drive(1'b1, 1, 8'hEE, 1'b0, 0, 4'h0);
        chk("cnt1_overwrite", cnt_of(1), 16);
`ifdef BRSF_MC_ERR_EN
        chk("ovf1", int'(ovf[1]), 1);
`endif
        for (int i = 0; i < D; i++) begin
            drive(1'b0, 0, 8'h00, 1'b1, 1, 4'h0);
            chk("drain1_ack", int'(ack), 1);
            chk("drain1_do", int'(dout), int'(dat(i)));
        end
        chk("ef1_drained", int'(ef[1]), 1);

        // Interleaved channels.
        drive(1'b1, 0, 8'hA5, 1'b0, 0, 4'h0);
        drive(1'b1, 3, 8'h3C, 1'b0, 0, 4'h0);
        drive(1'b0, 0, 8'h00, 1'b1, 3, 4'h0);
        chk("il_do3", int'(dout), 8'h3C);
        chk("il_sel3", int'(acksel), 3);
        drive(1'b0, 0, 8'h00, 1'b1, 0, 4'h0);
        chk("il_do0", int'(dout), 8'hA5);
        chk("il_sel0", int'(acksel), 0);

        // Same-cycle write and read on an empty, then one-word, channel.
        drive(1'b1, 2, 8'h11, 1'b1, 2, 4'h0);
        chk("sc_cnt_a", cnt_of(2), 1);
        chk("sc_ack_a", int'(ack), 0);
        drive(1'b1, 2, 8'h22, 1'b1, 2, 4'h0);
        chk("sc_cnt_b", cnt_of(2), 1);
        chk("sc_ack_b", int'(ack), 1);
        chk("sc_do_b", int'(dout), 8'h11);
        drive(1'b0, 0, 8'h00, 1'b1, 2, 4'h0);

        // Clear channel 1 with a read pending on it; channel 0 survives.
        for (int i = 0; i < 5; i++) drive(1'b1, 1, 8'(8'h50 + i), 1'b0, 0, 4'h0);
        for (int i = 0; i < 3; i++) drive(1'b1, 0, 8'(8'h30 + i), 1'b0, 0, 4'h0);
        drive(1'b0, 0, 8'h00, 1'b1, 1, 4'h2);
        chk("clr_ack", int'(ack), 0);
        chk("clr_cnt1", cnt_of(1), 0);
        chk("clr_ef1", int'(ef[1]), 1);
        chk("clr_cnt0", cnt_of(0), 3);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 0, 8'h00, 1'b1, 0, 4'h0);
            chk("clr_keep_do", int'(dout), 8'h30 + i);
        end

        // Full channel with simultaneous read and write.
        for (int i = 0; i < D; i++) drive(1'b1, 3, dat(i + 3), 1'b0, 0, 4'h0);
        drive(1'b1, 3, 8'hAA, 1'b1, 3, 4'h0);
        chk("fullrw_cnt", cnt_of(3), 15);
        chk("fullrw_af", int'(af[3]), 1);
        chk("fullrw_ff", int'(ff[3]), 0);
        chk("fullrw_do", int'(dout), int'(dat(3)));
        for (int i = 0; i < D - 1; i++) drive(1'b0, 0, 8'h00, 1'b1, 3, 4'h0);

        // Random traffic centred on channel 3 so its pointers wrap several times.
        pushes3 = 0;
        for (int i = 0; i < 900; i++) begin
            bit wheavy;
            wheavy = ((i / 40) % 2) == 0;
            we   = wheavy ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            re   = wheavy ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            wsel = ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : 2'd3;
            rsel = ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : 2'd3;
            di   = 8'($urandom);
            clr  = '0;
            tick();
        end
        we = 1'b0;
        re = 1'b0;
        chk("wrap_pushes_ge_3D", int'(pushes3 >= 3 * D), 1);

        // Reset with a read in flight.
        drive(1'b1, 0, 8'h77, 1'b0, 0, 4'h0);
        re   = 1'b1;
        rsel = 2'd0;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        re  = 1'b0;
        chk("rstmid_ack", int'(ack), 0);
        chk("rstmid_ef", int'(ef), 15);
        chk("rstmid_cnt", int'(cnt), 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
